// File: rtl/nonzero_index_scanner.sv
// Walks a nonzero mask lowest bit first, using an external priority encoder,
// and streams zero-based indices with valid/ready plus an end-of-mask summary.
module nonzero_index_scanner #(
  parameter  int unsigned SIZE  = 4,
  localparam int unsigned CNT_W = $clog2(SIZE + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mask_valid_i,
  output logic             mask_ready_o,
  input  logic [SIZE-1:0]  mask_i,
  output logic [SIZE-1:0]  enc_mask_o,
  input  logic [SIZE-1:0]  enc_pos_i,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic [SIZE-1:0]  idx_o,
  output logic             idx_last_o,
  output logic             done_o,
  output logic [CNT_W-1:0] nz_count_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SIZE-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             enc_none;

  assign enc_none   = (enc_pos_i == '0);
  assign enc_mask_o = rem_q;
  assign nz_count_o = cnt_q;
  assign err_o      = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // An encoder reporting "none" while bits remain is a fault: abort the mask.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (mask_valid_i) begin
          rem_d   = mask_i;
          cnt_d   = '0;
          state_d = (mask_i != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (enc_none) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (idx_ready_i) begin
          rem_d = rem_q & ~(SIZE'(1) << idx_o);
          cnt_d = cnt_q + CNT_W'(1);
          if (idx_last_o) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        rem_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mask_ready_o = 1'b0;
    idx_valid_o  = 1'b0;
    done_o       = 1'b0;
    idx_o        = enc_pos_i - SIZE'(1);
    idx_last_o   = ((rem_q & (rem_q - SIZE'(1))) == '0);
    case (state_q)
      IDLE:    mask_ready_o = 1'b1;
      SCAN:    idx_valid_o  = !enc_none;
      DONE:    done_o       = 1'b1;
      default: mask_ready_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_nonzero_index_scanner.sv
// Scoreboard bench for nonzero_index_scanner: drivers push expected indices and
// end-of-mask summaries, a negedge monitor pops and compares them.
module tb_nonzero_index_scanner;
  localparam int unsigned SIZE  = 4;
  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  typedef struct { int idx; bit last; } idx_exp_t;
  typedef struct { int cnt; int cyc; bit err; } done_exp_t;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             mask_valid_i = 1'b0;
  logic             mask_ready_o;
  logic [SIZE-1:0]  mask_i = '0;
  logic [SIZE-1:0]  enc_mask_o;
  logic [SIZE-1:0]  enc_pos_i;
  logic             idx_valid_o;
  logic             idx_ready_i = 1'b0;
  logic [SIZE-1:0]  idx_o;
  logic             idx_last_o;
  logic             done_o;
  logic [CNT_W-1:0] nz_count_o;
  logic             err_o;

  idx_exp_t  exp_idx_q[$];
  done_exp_t exp_done_q[$];
  int        n_vec = 0;
  int        n_err = 0;
  int        cyc = 0;
  int        rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
  bit        force_zero = 1'b0;
  bit        exp_err = 1'b0;
  bit        stalled = 1'b0;

  nonzero_index_scanner #(.SIZE(SIZE)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .mask_valid_i (mask_valid_i),
    .mask_ready_o (mask_ready_o),
    .mask_i       (mask_i),
    .enc_mask_o   (enc_mask_o),
    .enc_pos_i    (enc_pos_i),
    .idx_valid_o  (idx_valid_o),
    .idx_ready_i  (idx_ready_i),
    .idx_o        (idx_o),
    .idx_last_o   (idx_last_o),
    .done_o       (done_o),
    .nz_count_o   (nz_count_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Priority encoder stand-in: 1-based lowest set bit, 0 = none (or forced fault).
  always_comb begin
    enc_pos_i = '0;
    if (!force_zero) begin
      for (int b = SIZE - 1; b >= 0; b--) begin
        if (enc_mask_o[b]) enc_pos_i = SIZE'(b + 1);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      case (rdy_mode)
        0:       idx_ready_i = ($urandom_range(0, 3) != 0);
        1:       idx_ready_i = 1'b1;
        default: idx_ready_i = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: set bits of the mask in ascending order, the highest one flagged last.
  task automatic push_exp(input logic [SIZE-1:0] m, input bit frc, input int n);
    int        bits[$];
    done_exp_t d;
    for (int b = 0; b < SIZE; b++) if (m[b]) bits.push_back(b);
    if (frc && bits.size() != 0) begin
      exp_err = 1'b1;
      d.cnt   = 0;
      d.cyc   = n + 2;
    end else begin
      foreach (bits[i]) exp_idx_q.push_back('{idx: bits[i], last: (i == bits.size() - 1)});
      d.cnt = bits.size();
      d.cyc = (bits.size() == 0 || rdy_mode == 1) ? n + bits.size() + 1 : -1;
    end
    d.err = exp_err;
    exp_done_q.push_back(d);
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      stalled = 1'b0;
    end else begin
      if (stalled) chk("valid_held_while_stalled", int'(idx_valid_o), 1);
      if (idx_valid_o) begin
        if (exp_idx_q.size() == 0) begin
          chk("unexpected_idx_valid", int'(idx_valid_o), 0);
        end else begin
          chk("idx", int'(idx_o), exp_idx_q[0].idx);
          chk("idx_last", int'(idx_last_o), int'(exp_idx_q[0].last));
          if (idx_ready_i) void'(exp_idx_q.pop_front());
        end
      end
      stalled = idx_valid_o && !idx_ready_i;
      if (done_o) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", int'(done_o), 0);
        end else begin
          done_exp_t d;
          d = exp_done_q.pop_front();
          chk("nz_count", int'(nz_count_o), d.cnt);
          chk("err_at_done", int'(err_o), int'(d.err));
          if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_ni       = 1'b0;
    mask_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    exp_idx_q.delete();
    exp_done_q.delete();
    exp_err = 1'b0;
  endtask

  task automatic chk_idle_state(input string tag);
    @(negedge clk_i);
    chk({tag, "_mask_ready"}, int'(mask_ready_o), 1);
    chk({tag, "_idx_valid"}, int'(idx_valid_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_enc_mask"}, int'(enc_mask_o), 0);
    chk({tag, "_nz_count"}, int'(nz_count_o), 0);
    chk({tag, "_err"}, int'(err_o), 0);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!mask_ready_o && guard < 200) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (guard >= 200) chk("mask_ready_timeout", int'(mask_ready_o), 1);
  endtask

  task automatic send(input logic [SIZE-1:0] m, input bit frc);
    @(posedge clk_i); #1;
    wait_ready();
    mask_valid_i = 1'b1;
    mask_i       = m;
    force_zero   = frc;
    push_exp(m, frc, cyc);
    @(posedge clk_i); #1;
    mask_valid_i = 1'b0;
    mask_i       = SIZE'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_idx_q.size() != 0 || exp_done_q.size() != 0) && guard < 300) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (guard >= 300) chk("drain_timeout", exp_done_q.size(), 0);
    force_zero = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_idle_state("reset");

    // Three set bits at full throughput.
    rdy_mode = 1;
    send(4'b1011, 1'b0);
    drain();

    // Empty mask goes straight to the summary; ready returns the cycle after.
    send(4'b0000, 1'b0);
    drain();
    chk("ready_after_zero_mask", int'(mask_ready_o), 1);

    // Single bit held under backpressure for three cycles.
    rdy_mode = 2;
    send(4'b1000, 1'b0);
    repeat (3) begin @(posedge clk_i); #1; end
    rdy_mode = 1;
    drain();

    // Reset one cycle after the first index is taken aborts the mask.
    send(4'b1111, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    exp_idx_q.delete();
    exp_done_q.delete();
    repeat (3) chk_idle_state("post_abort");

    // Encoder fault: no indices, summary next cycle, sticky error until reset.
    send(4'b0110, 1'b1);
    drain();
    send(4'b0101, 1'b0);
    drain();
    chk("err_sticky", int'(err_o), 1);
    do_reset();
    chk_idle_state("err_cleared");

    // Mask valid held through a scan: the new mask is taken only back in IDLE.
    @(posedge clk_i); #1;
    wait_ready();
    mask_valid_i = 1'b1;
    mask_i       = 4'b1001;
    push_exp(4'b1001, 1'b0, cyc);
    @(posedge clk_i); #1;
    mask_i = 4'b0110;
    wait_ready();
    push_exp(4'b0110, 1'b0, cyc);
    @(posedge clk_i); #1;
    mask_valid_i = 1'b0;
    drain();

    // Random masks under random or full-rate backpressure.
    repeat (40) begin
      rdy_mode = int'($urandom_range(0, 1));
      send(SIZE'($urandom), 1'b0);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
